// File: rtl/mem_port_arbiter.sv
// Purpose: shares one fixed-latency memory port between fetch and data; data wins (optional ARB_STARVE_GUARD_EN fetch guard).
// Latency: request in IDLE at cycle 0 -> MemReq at 1, read sampled at LATENCY, valid pulse at LATENCY+1, next arbitration at LATENCY+2.
// Backpressure: requesters hold their request until the valid pulse; the stall outputs freeze the stages meanwhile.
module mem_port_arbiter #(
    parameter int LATENCY     = 2,
    parameter int MAX_DSTREAK = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ireq,
    input  logic [31:0] i_iaddr,
    output logic [31:0] o_irdata,
    output logic        o_ivalid,
    input  logic        i_dreq,
    input  logic        i_dwrite,
    input  logic [31:0] i_daddr,
    input  logic [31:0] i_dwdata,
    input  logic [3:0]  i_dbyte_en,
    output logic [31:0] o_drdata,
    output logic        o_dvalid,
    output logic        o_mem_req,
    output logic        o_mem_write,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_byte_en,
    input  logic [31:0] i_mem_rdata,
    output logic        o_fetch_stall,
    output logic        o_data_stall
);
    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_owner_d;
    logic          r_mem_req;
    logic          r_mem_write;
    logic [31:0]   r_mem_addr;
    logic [31:0]   r_mem_wdata;
    logic [3:0]    r_mem_byte_en;
    logic [31:0]   r_irdata;
    logic [31:0]   r_drdata;
    logic          r_ivalid;
    logic          r_dvalid;
    logic          w_grant_d;
    logic          w_arb;

    assign w_arb = (r_state == S_IDLE) && (i_ireq || i_dreq);

`ifdef ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(MAX_DSTREAK + 1);
    logic [SW-1:0] r_dstreak;
    logic          w_starve;

    // Streak never passes MAX_DSTREAK: at the limit a waiting fetch takes the next grant.
    assign w_starve  = i_ireq && (r_dstreak == SW'(MAX_DSTREAK));
    assign w_grant_d = i_dreq && !w_starve;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dstreak <= '0;
        end else if (w_arb) begin
            if (w_grant_d && i_ireq) r_dstreak <= r_dstreak + 1'b1;
            else                     r_dstreak <= '0;
        end
    end
`else
    assign w_grant_d = i_dreq;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_owner_d     <= 1'b0;
            r_mem_req     <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_mem_byte_en <= '0;
            r_irdata      <= '0;
            r_drdata      <= '0;
            r_ivalid      <= 1'b0;
            r_dvalid      <= 1'b0;
        end else begin
            r_mem_req <= 1'b0;
            r_ivalid  <= 1'b0;
            r_dvalid  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_arb) begin
                        r_owner_d     <= w_grant_d;
                        r_mem_req     <= 1'b1;
                        r_mem_write   <= w_grant_d && i_dwrite;
                        r_mem_addr    <= w_grant_d ? i_daddr : i_iaddr;
                        r_mem_wdata   <= w_grant_d ? i_dwdata : 32'h0;
                        r_mem_byte_en <= w_grant_d ? i_dbyte_en : 4'h0;
                        r_cnt         <= CW'(LATENCY);
                        r_state       <= S_ISSUE;
                    end
                end
                // The countdown starts in the strobe cycle, so LATENCY=1 samples during ISSUE itself.
                S_ISSUE, S_WAIT: begin
                    if (r_cnt == CW'(1)) begin
                        if (!r_owner_d) begin
                            r_irdata <= i_mem_rdata;
                            r_ivalid <= 1'b1;
                        end else begin
                            if (!r_mem_write) r_drdata <= i_mem_rdata;
                            r_dvalid <= 1'b1;
                        end
                        r_state <= S_DONE;
                    end else begin
                        r_cnt   <= r_cnt - 1'b1;
                        r_state <= S_WAIT;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_irdata      = r_irdata;
    assign o_ivalid      = r_ivalid;
    assign o_drdata      = r_drdata;
    assign o_dvalid      = r_dvalid;
    assign o_mem_req     = r_mem_req;
    assign o_mem_write   = r_mem_write;
    assign o_mem_addr    = r_mem_addr;
    assign o_mem_wdata   = r_mem_wdata;
    assign o_mem_byte_en = r_mem_byte_en;
    assign o_fetch_stall = i_ireq && !r_ivalid;
    assign o_data_stall  = i_dreq && !r_dvalid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table of single accesses plus hand-written
// sequences for contention, starvation guard, mid-access reset and LATENCY=1.
module tb_mem_port_arbiter;
    localparam int LAT = 2;
    localparam logic [31:0] GARB = 32'hBAD0BAD0;

    logic        clk, rst_n;
    logic        ireq, dreq, dwrite, dreq1;
    logic [31:0] iaddr, daddr, dwdata, mem_rdata;
    logic [3:0]  dbe;
    logic [31:0] irdata, drdata, mem_addr, mem_wdata;
    logic        ivalid, dvalid, mem_req, mem_write, fstall, dstall;
    logic [3:0]  mem_be;
    logic [31:0] irdata1, drdata1, mem_addr1, mem_wdata1;
    logic        ivalid1, dvalid1, mem_req1, mem_write1, fstall1, dstall1;
    logic [3:0]  mem_be1;

    int n_checks = 0;
    int n_err    = 0;

    mem_port_arbiter #(.LATENCY(LAT), .MAX_DSTREAK(4)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_ireq(ireq), .i_iaddr(iaddr), .o_irdata(irdata), .o_ivalid(ivalid),
        .i_dreq(dreq), .i_dwrite(dwrite), .i_daddr(daddr), .i_dwdata(dwdata),
        .i_dbyte_en(dbe), .o_drdata(drdata), .o_dvalid(dvalid),
        .o_mem_req(mem_req), .o_mem_write(mem_write), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .o_mem_byte_en(mem_be), .i_mem_rdata(mem_rdata),
        .o_fetch_stall(fstall), .o_data_stall(dstall)
    );

    mem_port_arbiter #(.LATENCY(1), .MAX_DSTREAK(4)) u_dut_lat1 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_ireq(1'b0), .i_iaddr(iaddr), .o_irdata(irdata1), .o_ivalid(ivalid1),
        .i_dreq(dreq1), .i_dwrite(dwrite), .i_daddr(daddr), .i_dwdata(dwdata),
        .i_dbyte_en(dbe), .o_drdata(drdata1), .o_dvalid(dvalid1),
        .o_mem_req(mem_req1), .o_mem_write(mem_write1), .o_mem_addr(mem_addr1),
        .o_mem_wdata(mem_wdata1), .o_mem_byte_en(mem_be1), .i_mem_rdata(mem_rdata),
        .o_fetch_stall(fstall1), .o_data_stall(dstall1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic        is_d;
        logic        dwrite;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
        logic [31:0] exp_irdata;
        logic [31:0] exp_drdata;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Single isolated access starting at the current negedge (cycle 0).
    task automatic run_vec(input vec_t v);
        ireq      = !v.is_d;
        dreq      = v.is_d;
        dwrite    = v.dwrite;
        iaddr     = v.is_d ? 32'h0 : v.addr;
        daddr     = v.is_d ? v.addr : 32'h0;
        dwdata    = v.wdata;
        dbe       = v.be;
        mem_rdata = GARB;
        #1;
        check({v.name, "/fstall0"}, fstall, !v.is_d);
        check({v.name, "/dstall0"}, dstall, v.is_d);
        for (int c = 1; c <= LAT + 1; c++) begin
            @(negedge clk);
            check({v.name, "/mem_req"}, mem_req, c == 1);
            if (c == 1) begin
                check({v.name, "/mem_addr"},  mem_addr,  v.addr);
                check({v.name, "/mem_write"}, mem_write, v.is_d && v.dwrite);
                check({v.name, "/mem_wdata"}, mem_wdata, v.is_d ? v.wdata : 32'h0);
                check({v.name, "/mem_be"},    mem_be,    v.is_d ? v.be : 4'h0);
            end
            check({v.name, "/ivalid"}, ivalid, !v.is_d && c == LAT + 1);
            check({v.name, "/dvalid"}, dvalid, v.is_d && c == LAT + 1);
            if (c <= LAT) check({v.name, "/fstall"}, fstall, !v.is_d);
            if (c == LAT) mem_rdata = v.rdata;
            if (c == LAT + 1) begin
                check({v.name, "/irdata"}, irdata, v.exp_irdata);
                check({v.name, "/drdata"}, drdata, v.exp_drdata);
                ireq      = 1'b0;
                dreq      = 1'b0;
                mem_rdata = GARB;
            end
        end
        @(negedge clk);
        check({v.name, "/idle_req"}, mem_req, 1'b0);
        check({v.name, "/idle_val"}, ivalid | dvalid, 1'b0);
    endtask

    vec_t vecs[5];
    vec_t rv;
    logic [31:0] exp_seq[6];

    initial begin
        vecs[0] = '{"fetch100", 1'b0, 1'b0, 32'h100, 32'h0,        4'h0,    32'hDEADBEEF, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{"load200",  1'b1, 1'b0, 32'h200, 32'h0,        4'hF,    32'hCAFEF00D, 32'hDEADBEEF, 32'hCAFEF00D};
        vecs[2] = '{"store40",  1'b1, 1'b1, 32'h40,  32'h12345678, 4'b0011, 32'h55555555, 32'hDEADBEEF, 32'hCAFEF00D};
        vecs[3] = '{"fetch104", 1'b0, 1'b0, 32'h104, 32'h0,        4'h0,    32'h00000013, 32'h00000013, 32'hCAFEF00D};
        vecs[4] = '{"load44",   1'b1, 1'b0, 32'h44,  32'h0,        4'hF,    32'hA5A5A5A5, 32'h00000013, 32'hA5A5A5A5};
        rv      = '{"postrst",  1'b0, 1'b0, 32'h180, 32'h0,        4'h0,    32'h76543210, 32'h76543210, 32'h0};

        rst_n = 1'b0; ireq = 1'b1; dreq = 1'b0; dreq1 = 1'b0; dwrite = 1'b0;
        iaddr = 32'h0; daddr = 32'h0; dwdata = 32'h0; dbe = 4'h0; mem_rdata = GARB;

        // Reset state
        @(negedge clk); @(negedge clk);
        check("rst/mem_req", mem_req, 1'b0);
        check("rst/ivalid",  ivalid,  1'b0);
        check("rst/dvalid",  dvalid,  1'b0);
        check("rst/irdata",  irdata,  32'h0);
        check("rst/drdata",  drdata,  32'h0);
        check("rst/mem_addr", mem_addr, 32'h0);
        check("rst/fstall",  fstall,  1'b1);
        check("rst/dstall",  dstall,  1'b0);
        ireq = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Simultaneous fetch and load: data first, fetch at next IDLE
        ireq = 1'b1; iaddr = 32'h300; dreq = 1'b1; dwrite = 1'b0; daddr = 32'h200;
        @(negedge clk);                                   // cycle 1
        check("both/c1_req",  mem_req,  1'b1);
        check("both/c1_addr", mem_addr, 32'h200);
        check("both/c1_fst",  fstall,   1'b1);
        @(negedge clk);                                   // cycle 2
        mem_rdata = 32'h11112222;
        @(negedge clk);                                   // cycle 3
        check("both/c3_dval", dvalid, 1'b1);
        check("both/c3_ival", ivalid, 1'b0);
        check("both/c3_drd",  drdata, 32'h11112222);
        dreq = 1'b0; mem_rdata = GARB;
        @(negedge clk);                                   // cycle 4
        check("both/c4_req", mem_req, 1'b0);
        check("both/c4_fst", fstall,  1'b1);
        @(negedge clk);                                   // cycle 5
        check("both/c5_req",  mem_req,  1'b1);
        check("both/c5_addr", mem_addr, 32'h300);
        @(negedge clk);                                   // cycle 6
        mem_rdata = 32'h33334444;
        @(negedge clk);                                   // cycle 7
        check("both/c7_ival", ivalid, 1'b1);
        check("both/c7_ird",  irdata, 32'h33334444);
        check("both/c7_drd",  drdata, 32'h11112222);
        ireq = 1'b0; mem_rdata = GARB;
        @(negedge clk);

        // Both requests held continuously
`ifdef ARB_STARVE_GUARD_EN
        exp_seq = '{32'h500, 32'h500, 32'h500, 32'h500, 32'h600, 32'h500};
`else
        exp_seq = '{32'h500, 32'h500, 32'h500, 32'h500, 32'h500, 32'h500};
`endif
        dreq = 1'b1; dwrite = 1'b0; daddr = 32'h500; ireq = 1'b1; iaddr = 32'h600;
        for (int g = 0; g < 6; g++) begin
            int k;
            k = 0;
            while (!mem_req && k < 12) begin
                @(negedge clk);
                k++;
            end
            if (k == 12) check($sformatf("starve/timeout%0d", g), 1'b1, 1'b0);
            check($sformatf("starve/grant%0d", g), mem_addr, exp_seq[g]);
            @(negedge clk);
        end
        ireq = 1'b0; dreq = 1'b0;
        repeat (6) @(negedge clk);

        // Reset pulsed during WAIT
        dreq = 1'b1; dwrite = 1'b0; daddr = 32'h700;
        @(negedge clk);
        check("rstmid/c1_req", mem_req, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstmid/req",    mem_req, 1'b0);
        check("rstmid/dvalid", dvalid,  1'b0);
        check("rstmid/drdata", drdata,  32'h0);
        check("rstmid/dstall", dstall,  1'b1);
        dreq = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("rstmid/nopulse%0d", c), ivalid | dvalid | mem_req, 1'b0);
        end
        run_vec(rv);

        // LATENCY=1 single load
        dreq1 = 1'b1; dwrite = 1'b0; daddr = 32'h800; mem_rdata = GARB;
        @(negedge clk);                                   // cycle 1
        check("lat1/c1_req",  mem_req1,  1'b1);
        check("lat1/c1_addr", mem_addr1, 32'h800);
        check("lat1/c1_wr",   mem_write1, 1'b0);
        check("lat1/c1_dval", dvalid1,   1'b0);
        mem_rdata = 32'h0BADCAFE;
        @(negedge clk);                                   // cycle 2
        check("lat1/c2_dval", dvalid1, 1'b1);
        check("lat1/c2_drd",  drdata1, 32'h0BADCAFE);
        dreq1 = 1'b0; mem_rdata = GARB;
        @(negedge clk);
        check("lat1/c3_dval", dvalid1,  1'b0);
        check("lat1/c3_req",  mem_req1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences a single-ported, fixed-latency unified memory between the Fetch stage (instruction reads) and the Memory stage (data loads/stores). Sits between the pipeline stages and the memory model. It grants one access at a time and returns read data with a one-cycle valid pulse. It produces the stall signals that freeze the PC (`FetchStall` feeds Fetch's `stall`) and the Memory stage (`DataStall`).

## Interface
- `LATENCY`, 2: memory read latency in cycles from the `MemReq` cycle to `MemRdata` being valid; must be ≥1.
- `MAX_DSTREAK`, 4: consecutive data grants allowed while a fetch waits (starvation guard only).
- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `IReq` in 1: fetch request; held with `IAddr` stable until `IValid`.
- `IAddr` in [0:31]: fetch address.
- `IRdata` out [0:31]: instruction word; valid when `IValid`=1.
- `IValid` out 1: one-cycle completion pulse for fetch.
- `DReq` in 1: data request; held stable with its fields until `DValid`.
- `DWrite` in 1: 1 means store, 0 means load.
- `DAddr` in [0:31]: data address.
- `DWdata` in [0:31]: store data.
- `DByteEn` in [0:3]: store byte enables.
- `DRdata` out [0:31]: load data; updated only by loads.
- `DValid` out 1: one-cycle completion pulse for data.
- `MemReq` out 1: one-cycle memory access strobe.
- `MemWrite`, `MemAddr` [0:31], `MemWdata` [0:31], `MemByteEn` [0:3` out: latched access fields.
- `MemRdata` in [0:31]: memory read data.
- `FetchStall` out 1: `IReq & ~IValid`.
- `DataStall` out 1: `DReq & ~DValid`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - If any request is present: pick the owner, latch the owner's fields into the Mem* registers, go to ISSUE.
  - With no request: stay in IDLE.
- **Arbitration (priority):** data wins over fetch, because data belongs to the older instruction. Exception: the starvation guard (see Configuration).
- **ISSUE**
  - `MemReq`=1 for exactly this cycle.
  - Load the wait counter with `LATENCY`, go to WAIT.
- **WAIT**
  - Decrement the counter each cycle.
  - In the cycle the counter reaches 1, sample `MemRdata` into `IRdata` (fetch) or `DRdata` (load), then go to DONE.
  - Stores sample nothing; `DRdata` keeps its previous value.
- **DONE**
  - Pulse the owner's `IValid`/`DValid` for exactly 1 cycle, go to IDLE.
  - Requests are not arbitrated in DONE.
  - The requester must drop or replace its request in the following cycle.
- `FetchStall`/`DataStall` are combinational from the request inputs and the valid pulses.
- Mem* field outputs hold their last value outside ISSUE. Only `MemReq` qualifies them.
- Request inputs changing during ISSUE/WAIT are ignored, because the fields are latched.
- A request dropped before completion still completes; the pulse is produced anyway.

## Timing
- Reset values: state IDLE; every output register and the streak counter are 0.
  - `IValid`, `DValid`, and `MemReq` are 0 during reset.
  - The stall outputs follow their equations.
- Access latency: a request seen in IDLE at cycle 0 gives:
  - `MemReq` at cycle 1;
  - `MemRdata` sampled at cycle `LATENCY`;
  - valid pulse at cycle `LATENCY`+1;
  - next arbitration at cycle `LATENCY`+2.
- Throughput: one access per `LATENCY`+2 cycles.
- Simultaneous `IReq` and `DReq` in IDLE: data is granted. Fetch stays stalled and is served at the next IDLE, unless data is requested again.
- Reset asserted mid-access:
  - Returns to IDLE asynchronously.
  - `MemReq` drops immediately.
  - No valid pulse is generated.
  - Any in-flight memory data is discarded.

## Configuration
- `ARB_STARVE_GUARD_EN` defined:
  - A counter tracks data grants made while `IReq`=1.
  - When the counter equals `MAX_DSTREAK` and both requests are present in IDLE, fetch is granted.
  - The counter clears on any fetch grant, or on a data grant made with `IReq`=0.
- Undefined: strict data priority; the counter logic is absent.

## Test plan
- Fetch only, `LATENCY`=2, `IReq` at cycle 0, `IAddr`=0x100, memory returns 0xDEADBEEF → `MemReq`=1 only at cycle 1 with `MemAddr`=0x100, `IValid`=1 at cycle 3 with `IRdata`=0xDEADBEEF, `FetchStall`=1 during cycles 0–2.
- `IReq` and `DReq` (load at 0x200) at the same cycle → data granted first, `DValid` at cycle 3, fetch `MemReq` at cycle 5, `IValid` at cycle 7.
- Store: `DWrite`=1, `DAddr`=0x40, `DWdata`=0x12345678, `DByteEn`=4'b0011 → Mem* fields match in the `MemReq` cycle; `DValid` pulses; `DRdata` is unchanged.
- With `ARB_STARVE_GUARD_EN`, `MAX_DSTREAK`=4, `DReq` and `IReq` both held continuously → 4 data grants, then 1 fetch grant, then data again. Without the macro, fetch is never granted.
- Reset pulsed low during WAIT → state IDLE, no `IValid`/`DValid` pulse; a fresh request after release completes normally at cycle `LATENCY`+1.
- `LATENCY`=1 single load → `MemReq` at cycle 1, data sampled at cycle 1, `DValid` at cycle 2.
